// File: rtl/clk_div_pkg.sv
// clk_div_pkg - shared types and defaults for the divided-clock monitor.
// Revision: 1.0
`default_nettype none
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } meas_state_e;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 65536;

endpackage
`default_nettype wire

// File: rtl/clk_div_meas_if.sv
// clk_div_meas_if - measured clock, expected ratio and measurement results.
// Revision: 1.0
`default_nettype none
interface clk_div_meas_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             clk_in;
  logic [CNT_W-1:0] exp_div;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             locked;
  logic             mismatch;
  logic             timeout;

  modport master (
    output clk_in, exp_div,
    input  meas_period, meas_high, meas_valid, locked, mismatch, timeout
  );

  modport slave (
    input  clk_in, exp_div,
    output meas_period, meas_high, meas_valid, locked, mismatch, timeout
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_edge_sync.sv
// clk_div_edge_sync - synchronizer chain plus one-cycle delay, giving level and edges.
// Revision: 1.0
`default_nettype none
module clk_div_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic s_d;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain <= '0;
        end else begin
          chain[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign s = chain[SYNC_STAGES-1];
    end else begin : g_direct
      // Only safe when din is already a product of clk.
      assign s = din;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule
`default_nettype wire

// File: rtl/clk_div_meas.sv
// clk_div_meas - measures period and high time of a divided clock; lock, mismatch, timeout.
// Revision: 1.0
`default_nettype none
module clk_div_meas
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  wire          clk,
  input  wire          rst_n,
  clk_div_meas_if.slave bus
);

  localparam int               MW       = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_CNT);

  logic             s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_nxt;
  logic             same;
  logic             new_mismatch;
  meas_state_e      state;

  clk_div_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.clk_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != TO_VAL) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end
      if (s && !fall && hi_cnt != TO_VAL) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    same         = (per_cnt == bus.meas_period) && (hi_cnt == bus.meas_high);
    match_nxt    = (match_cnt == '0 || !same) ? MW'(1) : match_cnt + MW'(1);
    new_mismatch = (bus.exp_div < MIN_DIV) || (per_cnt != bus.exp_div);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      match_cnt       <= '0;
      bus.meas_period <= '0;
      bus.meas_high   <= '0;
      bus.meas_valid  <= 1'b0;
      bus.locked      <= 1'b0;
      bus.mismatch    <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.meas_valid <= 1'b0;
      // A rise always beats a simultaneous saturated period counter.
      if (rise) begin
        bus.timeout <= 1'b0;
        case (state)
          IDLE: begin
            state     <= ACQ;
            match_cnt <= '0;
          end
          ACQ, LOCK: begin
            bus.meas_period <= per_cnt;
            bus.meas_high   <= hi_cnt;
            bus.meas_valid  <= 1'b1;
            bus.mismatch    <= new_mismatch;
            if (state == ACQ) begin
              match_cnt <= match_nxt;
              if (match_nxt >= LOCK_VAL) begin
                state      <= LOCK;
                bus.locked <= 1'b1;
              end
            end else if (!same) begin
              match_cnt  <= MW'(1);
              state      <= ACQ;
              bus.locked <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            match_cnt <= '0;
          end
        endcase
      end else if (per_cnt == TO_VAL) begin
        bus.timeout <= 1'b1;
        bus.locked  <= 1'b0;
        state       <= IDLE;
        match_cnt   <= '0;
      end
    end
  end

endmodule
`default_nettype wire
